// File: rtl/drum_pkg.sv
// rtl/drum_pkg.sv - shared constants and FSM state type for the drum audio output stage
// Holds the 1.17 sample format, audio core register map and the bus FSM encoding.
// No ports.
package drum_pkg;

  // Signed 1.17 centre-node amplitude: one sign/integer bit, 17 fraction bits.
  localparam int SAMPLE_W    = 18;
  localparam int SAMPLE_FRAC = 17;
  localparam int BUS_W       = 32;

  // Audio codec core register map.
  localparam logic [31:0] ADDR_FIFOSPACE = 32'h0000_0004;
  localparam logic [31:0] ADDR_LEFT      = 32'h0000_0008;
  localparam logic [31:0] ADDR_RIGHT     = 32'h0000_000C;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SPACE  = 3'd1,
    CHK_SPACE = 3'd2,
    WR_LEFT   = 3'd3,
    WR_RIGHT  = 3'd4,
    POP       = 3'd5
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// rtl/sample_fifo.sv - small register-based synchronous sample FIFO
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   push, push_data   write request and data; accepted when not full or when popping
//   pop               remove head entry (ignored when empty)
//   head              current head entry (valid when !empty)
//   level             entries held, 0..DEPTH
//   full, empty       level flags
//   dropped           1-cycle pulse: a push was refused because the FIFO was full
module sample_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             dropped
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);
  assign dropped = push && !do_push;
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/drum_audio_out.sv
// rtl/drum_audio_out.sv - buffers solver centre samples and writes them to the audio codec core
// Ports:
//   clk_50, reset               50 MHz clock, synchronous active-high reset
//   sample_in, sample_valid     1.17 centre amplitude and its end-of-sweep pulse
//   step_ready                  solver may start the next sweep (FIFO not full)
//   bus_addr/read/write/...     single-master register bus, request held until bus_ack
//   fifo_level                  samples buffered
//   drop_count                  samples lost to overflow, saturating
module drum_audio_out
  import drum_pkg::*;
#(
  parameter int          SAMPLE_W       = drum_pkg::SAMPLE_W,
  parameter int          FIFO_DEPTH     = 4,
  parameter logic [31:0] ADDR_FIFOSPACE = drum_pkg::ADDR_FIFOSPACE,
  parameter logic [31:0] ADDR_LEFT      = drum_pkg::ADDR_LEFT,
  parameter logic [31:0] ADDR_RIGHT     = drum_pkg::ADDR_RIGHT
) (
  input  logic                          clk_50,
  input  logic                          reset,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          step_ready,
  output logic [31:0]                   bus_addr,
  output logic                          bus_read,
  output logic                          bus_write,
  output logic [31:0]                   bus_writedata,
  input  logic [31:0]                   bus_readdata,
  input  logic                          bus_ack,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   drop_count
);

  state_t              state;
  state_t              state_next;
  logic [15:0]         space_reg;
  logic [SAMPLE_W-1:0] head;
  logic                full;
  logic                empty;
  logic                dropped;
  logic                pop;
  logic                unused_readdata;

  // Only the write-space byte counts of the fifospace register matter.
  assign unused_readdata = ^bus_readdata[15:0];

  sample_fifo #(
    .WIDTH (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_50),
    .reset     (reset),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (pop),
    .head      (head),
    .level     (fifo_level),
    .full      (full),
    .empty     (empty),
    .dropped   (dropped)
  );

  assign step_ready = !full;

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state      <= IDLE;
      space_reg  <= '0;
      drop_count <= '0;
    end else begin
      state <= state_next;
      if (state == RD_SPACE && bus_ack) begin
        space_reg <= bus_readdata[31:16];
      end
      if (dropped && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // The head stays in the FIFO until both channels are written, so the
  // write data is stable for as long as the bus stalls.
  always_comb begin
    state_next    = state;
    bus_read      = 1'b0;
    bus_write     = 1'b0;
    bus_addr      = '0;
    bus_writedata = '0;
    pop           = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) state_next = RD_SPACE;
      end
      RD_SPACE: begin
        bus_read = 1'b1;
        bus_addr = ADDR_FIFOSPACE;
        if (bus_ack) state_next = CHK_SPACE;
      end
      CHK_SPACE: begin
        // Left and right write-space counts must both be nonzero, else poll again.
        if (space_reg[15:8] != 8'd0 && space_reg[7:0] != 8'd0) state_next = WR_LEFT;
        else                                                  state_next = RD_SPACE;
      end
      WR_LEFT: begin
        bus_write     = 1'b1;
        bus_addr      = ADDR_LEFT;
        bus_writedata = {head, {(32 - SAMPLE_W){1'b0}}};
        if (bus_ack) state_next = WR_RIGHT;
      end
      WR_RIGHT: begin
        bus_write     = 1'b1;
        bus_addr      = ADDR_RIGHT;
        bus_writedata = {head, {(32 - SAMPLE_W){1'b0}}};
        if (bus_ack) state_next = POP;
      end
      POP: begin
        pop        = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_drum_audio_out.sv
// tb/tb_drum_audio_out.sv - scoreboard testbench for drum_audio_out
module tb_drum_audio_out;
  import drum_pkg::*;

  localparam logic [31:0] SPACE_OK = 32'h0101_0000;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic [17:0] sample_in;
  logic        sample_valid;
  logic        step_ready;
  logic [31:0] bus_addr;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;
  logic        bus_ack;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;

  always #10 clk_50 = ~clk_50;

  drum_audio_out dut (
    .clk_50        (clk_50),
    .reset         (reset),
    .sample_in     (sample_in),
    .sample_valid  (sample_valid),
    .step_ready    (step_ready),
    .bus_addr      (bus_addr),
    .bus_read      (bus_read),
    .bus_write     (bus_write),
    .bus_writedata (bus_writedata),
    .bus_readdata  (bus_readdata),
    .bus_ack       (bus_ack),
    .fifo_level    (fifo_level),
    .drop_count    (drop_count)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         obs_q[$];
  wr_t         exp_q[$];
  logic [31:0] space_q[$];
  logic [31:0] rd_val = SPACE_OK;
  logic        ack_rd = 1'b1;
  logic        ack_wr = 1'b1;
  int          cyc = 0;
  int          n_reads = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_push_cyc = 0;

  // Bus slave: acks in the same cycle a request is issued, when enabled.
  assign bus_ack      = (bus_read && ack_rd) || (bus_write && ack_wr);
  assign bus_readdata = rd_val;

  always @(posedge clk_50) cyc <= cyc + 1;

  // Monitor: present the next fifospace value, record completed transfers.
  always @(negedge clk_50) begin
    rd_val = (space_q.size() > 0) ? space_q[0] : SPACE_OK;
    if (!reset) begin
      if (bus_write && bus_ack) obs_q.push_back('{addr: bus_addr, data: bus_writedata, cyc: cyc});
      if (bus_read && bus_ack) begin
        n_reads++;
        if (space_q.size() > 0) void'(space_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] fmt(input logic [17:0] s);
    return {s, 14'b0};
  endfunction

  task automatic push_sample(input logic [17:0] s, input bit keep, input logic [31:0] word);
    sample_in    = s;
    sample_valid = 1'b1;
    @(posedge clk_50); #1;
    sample_valid  = 1'b0;
    last_push_cyc = cyc;
    if (keep) begin
      exp_q.push_back('{addr: ADDR_LEFT,  data: word, cyc: 0});
      exp_q.push_back('{addr: ADDR_RIGHT, data: word, cyc: 0});
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_50);
      if (fifo_level == 3'd0 && !bus_read && !bus_write) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sample_valid = 1'b0; sample_in = '0;
    repeat (2) @(posedge clk_50);
    #1 reset = 1'b0;
    @(negedge clk_50);
    n_cmp++; if (step_ready !== 1'b1) begin n_bad++; $display("FAIL reset_step_ready got %b want 1", step_ready); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    n_cmp++; if (bus_read !== 1'b0 || bus_write !== 1'b0) begin n_bad++; $display("FAIL reset_req got rd=%b wr=%b want 0/0", bus_read, bus_write); end
    n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_drop got %0d want 0", drop_count); end
    n_cmp++; if (bus_addr !== 32'd0 || bus_writedata !== 32'd0) begin n_bad++; $display("FAIL reset_bus got addr=%h data=%h want 0/0", bus_addr, bus_writedata); end
  endtask

  task automatic test_single(input string name, input logic [17:0] s, input logic [31:0] word);
    bit  ok;
    wr_t e, o;
    obs_q.delete(); exp_q.delete();
    push_sample(s, 1'b1, word);
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL %s_timeout level=%0d want drained", name, fifo_level); end
    n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL %s_count got %0d want 2", name, obs_q.size()); end
    n_cmp++; if (obs_q.size() > 0 && obs_q[0].cyc - last_push_cyc != 3) begin
      n_bad++; $display("FAIL %s_latency got %0d want 3", name, obs_q[0].cyc - last_push_cyc);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL %s_write got %h:%h want %h:%h", name, o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_codec_full();
    bit  ok;
    int  r0;
    wr_t e, o;
    obs_q.delete(); exp_q.delete();
    repeat (5) space_q.push_back(32'h0000_0000);
    space_q.push_back(32'h0100_0000);
    space_q.push_back(32'h0101_0000);
    @(negedge clk_50);
    r0 = n_reads;
    push_sample(18'h1_2345, 1'b1, fmt(18'h1_2345));
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_timeout level=%0d want drained", fifo_level); end
    n_cmp++; if (n_reads - r0 != 7) begin n_bad++; $display("FAIL full_polls got %0d want 7", n_reads - r0); end
    n_cmp++; if (obs_q.size() != 2) begin n_bad++; $display("FAIL full_count got %0d want 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL full_write got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_overflow();
    bit          ok;
    wr_t         e, o;
    logic [17:0] s;
    obs_q.delete(); exp_q.delete();
    ack_rd = 1'b0; ack_wr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = 18'(i * 18'h0_1111 + 18'h2_0001);
      push_sample(s, i < 4, fmt(s));
    end
    n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    n_cmp++; if (step_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_step_ready got %b want 0", step_ready); end
    n_cmp++; if (drop_count !== 16'd2) begin n_bad++; $display("FAIL ovf_drop got %0d want 2", drop_count); end
    n_cmp++; if (bus_read !== 1'b1) begin n_bad++; $display("FAIL ovf_read_held got %b want 1", bus_read); end
    ack_rd = 1'b1; ack_wr = 1'b1;
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_timeout level=%0d want drained", fifo_level); end
    n_cmp++; if (obs_q.size() != 8) begin n_bad++; $display("FAIL ovf_count got %0d want 8", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL ovf_write got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_push_at_pop();
    bit          ok;
    bit          found;
    wr_t         e, o;
    logic [17:0] s;
    obs_q.delete(); exp_q.delete();
    ack_rd = 1'b0; ack_wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = 18'(18'h3_F000 - i * 18'h0_0F0F);
      push_sample(s, 1'b1, fmt(s));
    end
    ack_rd = 1'b1; ack_wr = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_50);
      if (bus_write && bus_ack && bus_addr == ADDR_RIGHT) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL pp_right_ack got none want ack on ADDR_RIGHT"); end
    // Next edge enters POP; the push then lands on the POP edge itself.
    @(posedge clk_50); #1;
    push_sample(18'h0_5A5A, 1'b1, fmt(18'h0_5A5A));
    n_cmp++; if (fifo_level !== 3'd4) begin n_bad++; $display("FAIL pp_level got %0d want 4", fifo_level); end
    n_cmp++; if (drop_count !== 16'd2) begin n_bad++; $display("FAIL pp_drop got %0d want 2", drop_count); end
    wait_idle(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL pp_timeout level=%0d want drained", fifo_level); end
    n_cmp++; if (obs_q.size() != 10) begin n_bad++; $display("FAIL pp_count got %0d want 10", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_cmp++; if (o.addr !== e.addr || o.data !== e.data) begin
        n_bad++; $display("FAIL pp_write got %h:%h want %h:%h", o.addr, o.data, e.addr, e.data);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    bit found;
    obs_q.delete(); exp_q.delete();
    ack_rd = 1'b1; ack_wr = 1'b0;
    push_sample(18'h1_0F0F, 1'b0, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_50);
      if (bus_write && bus_addr == ADDR_LEFT) begin found = 1'b1; break; end
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rst_mid_reach got none want write to ADDR_LEFT"); end
    reset = 1'b1;
    @(posedge clk_50); #1;
    n_cmp++; if (bus_write !== 1'b0 || bus_read !== 1'b0) begin n_bad++; $display("FAIL rst_mid_req got rd=%b wr=%b want 0/0", bus_read, bus_write); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL rst_mid_level got %0d want 0", fifo_level); end
    reset  = 1'b0;
    ack_wr = 1'b1;
    repeat (6) @(negedge clk_50);
    n_cmp++; if (obs_q.size() != 0) begin n_bad++; $display("FAIL rst_mid_writes got %0d want 0", obs_q.size()); end
    n_cmp++; if (bus_read !== 1'b0 || drop_count !== 16'd0) begin n_bad++; $display("FAIL rst_mid_idle got rd=%b drop=%0d want 0/0", bus_read, drop_count); end
  endtask

  initial begin
    test_reset();
    test_single("single", 18'h0_8000, 32'h2000_0000);
    test_single("negative", 18'h3_FFFF, 32'hFFFF_C000);
    test_codec_full();
    test_overflow();
    test_push_at_pop();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
